// File: rtl/dcf77_pkg.sv
// Shared constants and types for the DCF77 bit decoder.
// Durations are counted in Goertzel power frames (2500 frames per second).
package dcf77_pkg;

    localparam int unsigned FRAMES_PER_SEC = 2500;

    // Default timing, in frames
    localparam int unsigned DEFAULT_DEBOUNCE   = 5;
    localparam int unsigned DEFAULT_BIT_MIN    = 175;   // 70 ms
    localparam int unsigned DEFAULT_BIT_SPLIT  = 375;   // 150 ms
    localparam int unsigned DEFAULT_BIT_MAX    = 625;   // 250 ms
    localparam int unsigned DEFAULT_MARK_MIN   = 3750;  // 1.5 s
    localparam int unsigned DEFAULT_LOS_FRAMES = 2500;  // 1 s
    localparam int unsigned DEFAULT_CNT_W      = 14;

    // Default slicer thresholds for the signed power word
    localparam logic [63:0] DEFAULT_THR_LOW  = 64'd1_000_000;
    localparam logic [63:0] DEFAULT_THR_HIGH = 64'd10_000_000;

    // One DCF77 minute carries seconds 0..58; second 59 has no reduction
    localparam int unsigned FRAME_BITS = 59;
    localparam logic [5:0]  LAST_INDEX = 6'd59;

    // Field positions inside the assembled frame (bit n = second n)
    localparam int unsigned MINUTE_LSB     = 21;
    localparam int unsigned MINUTE_MSB     = 27;
    localparam int unsigned PARITY_MINUTE  = 28;
    localparam int unsigned HOUR_LSB       = 29;
    localparam int unsigned HOUR_MSB       = 34;
    localparam int unsigned PARITY_HOUR    = 35;
    localparam int unsigned DAY_LSB        = 36;
    localparam int unsigned DAY_MSB        = 41;
    localparam int unsigned WEEKDAY_LSB    = 42;
    localparam int unsigned WEEKDAY_MSB    = 44;
    localparam int unsigned MONTH_LSB      = 45;
    localparam int unsigned MONTH_MSB      = 49;
    localparam int unsigned YEAR_LSB       = 50;
    localparam int unsigned YEAR_MSB       = 57;
    localparam int unsigned PARITY_DATE    = 58;

    // Decoder state
    typedef enum logic [1:0] {
        SYNC,
        ON,
        OFF,
        LOS
    } dcf_state_e;

endpackage

// File: rtl/carrier_slicer.sv
// Hysteresis comparator plus debounce: turns the per-frame power word into a
// clean carrier on/off level. toggle is high in the power_valid cycle whose
// frame flips the level, so carrier_on changes on the following edge.
module carrier_slicer
    import dcf77_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        power_valid,
    input  logic [63:0] power,
    input  logic [63:0] thr_low,
    input  logic [63:0] thr_high,
    output logic        carrier_on,
    output logic        toggle
);

    // Counter runs 0..DEBOUNCE-1; the DEBOUNCE-th disagreeing frame toggles
    localparam int unsigned DbW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DbW-1:0] DebLast = DbW'(DEBOUNCE - 1);

    logic           raw_q, raw_d;
    logic           carrier_q, carrier_d;
    logic [DbW-1:0] deb_q, deb_d;

    // Next raw level (low threshold wins) and debounce count
    always_comb begin
        raw_d     = raw_q;
        carrier_d = carrier_q;
        deb_d     = deb_q;
        toggle    = 1'b0;
        if (power_valid) begin
            if ($signed(power) < $signed(thr_low)) begin
                raw_d = 1'b0;
            end else if ($signed(power) > $signed(thr_high)) begin
                raw_d = 1'b1;
            end
            if (raw_d == carrier_q) begin
                deb_d = '0;
            end else if (deb_q == DebLast) begin
                toggle    = 1'b1;
                carrier_d = raw_d;
                deb_d     = '0;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    // Slicer state registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            raw_q     <= 1'b0;
            carrier_q <= 1'b0;
            deb_q     <= '0;
        end else begin
            raw_q     <= raw_d;
            carrier_q <= carrier_d;
            deb_q     <= deb_d;
        end
    end

    assign carrier_on = carrier_q;

endmodule

// File: rtl/dcf77_bit_decoder.sv
// DCF77 bit decoder: slices Goertzel power frames into carrier on/off,
// measures reductions, classifies them into bits, detects the minute marker
// and assembles the 59-bit time frame. All outputs are registered and update
// on the edge after the power_valid cycle that caused them.
module dcf77_bit_decoder
    import dcf77_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = DEFAULT_DEBOUNCE,
    parameter int unsigned BIT_MIN    = DEFAULT_BIT_MIN,
    parameter int unsigned BIT_SPLIT  = DEFAULT_BIT_SPLIT,
    parameter int unsigned BIT_MAX    = DEFAULT_BIT_MAX,
    parameter int unsigned MARK_MIN   = DEFAULT_MARK_MIN,
    parameter int unsigned LOS_FRAMES = DEFAULT_LOS_FRAMES,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  power_valid,
    input  logic [63:0]           power,
    input  logic [63:0]           thr_low,
    input  logic [63:0]           thr_high,
    output logic                  carrier_on,
    output logic                  bit_valid,
    output logic                  bit_value,
    output logic                  bit_error,
    output logic                  los,
    output logic [5:0]            bit_index,
    output logic                  minute_valid,
    output logic [FRAME_BITS-1:0] frame
);

    localparam logic [CNT_W-1:0] BitMinC   = CNT_W'(BIT_MIN);
    localparam logic [CNT_W-1:0] BitSplitC = CNT_W'(BIT_SPLIT);
    localparam logic [CNT_W-1:0] BitMaxC   = CNT_W'(BIT_MAX);
    localparam logic [CNT_W-1:0] MarkMinC  = CNT_W'(MARK_MIN);
    localparam logic [CNT_W-1:0] LosC      = CNT_W'(LOS_FRAMES);

    logic                  toggle;

    dcf_state_e            state_q, state_d;
    logic [CNT_W-1:0]      on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0]      off_cnt_q, off_cnt_d;
    logic [5:0]            index_q, index_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  los_q, los_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  bit_value_q, bit_value_d;
    logic                  bit_error_q, bit_error_d;
    logic                  minute_q, minute_d;
    logic                  accept;
    logic                  new_bit;

    carrier_slicer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_slicer (
        .clock       (clock),
        .reset_n     (reset_n),
        .power_valid (power_valid),
        .power       (power),
        .thr_low     (thr_low),
        .thr_high    (thr_high),
        .carrier_on  (carrier_on),
        .toggle      (toggle)
    );

    // Per-frame state machine: duration counters, bit classification, marker
    always_comb begin
        state_d     = state_q;
        on_cnt_d    = on_cnt_q;
        off_cnt_d   = off_cnt_q;
        index_d     = index_q;
        frame_d     = frame_q;
        los_d       = los_q;
        bit_value_d = bit_value_q;
        bit_valid_d = 1'b0;
        bit_error_d = 1'b0;
        minute_d    = 1'b0;
        accept      = 1'b0;
        new_bit     = 1'b0;

        if (power_valid) begin
            // Counters restart on every level change and saturate otherwise
            if (toggle) begin
                on_cnt_d  = '0;
                off_cnt_d = '0;
            end else if (carrier_on) begin
                on_cnt_d = (on_cnt_q == '1) ? on_cnt_q : on_cnt_q + 1'b1;
            end else begin
                off_cnt_d = (off_cnt_q == '1) ? off_cnt_q : off_cnt_q + 1'b1;
            end

            case (state_q)
                SYNC: begin
                    if (toggle) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (toggle) begin
                        state_d = OFF;
                        // A long carrier period is the missing second 59
                        if (on_cnt_q >= MarkMinC) begin
                            index_d = '0;
                            if (index_q == LAST_INDEX) begin
                                minute_d = 1'b1;
                            end
                        end
                    end
                end
                OFF: begin
                    if (toggle) begin
                        state_d = ON;
                        if (off_cnt_q < BitMinC) begin
                            bit_error_d = 1'b1;
                        end else if (off_cnt_q < BitSplitC) begin
                            accept  = 1'b1;
                            new_bit = 1'b0;
                        end else if (off_cnt_q <= BitMaxC) begin
                            accept  = 1'b1;
                            new_bit = 1'b1;
                        end else begin
                            bit_error_d = 1'b1;
                            index_d     = '0;
                        end
                    end else if (off_cnt_d == LosC) begin
                        state_d     = LOS;
                        los_d       = 1'b1;
                        bit_error_d = 1'b1;
                        index_d     = '0;
                    end
                end
                LOS: begin
                    if (toggle) begin
                        state_d = ON;
                        los_d   = 1'b0;
                    end
                end
                default: state_d = SYNC;
            endcase

            // A bit beyond second 58 means the marker was missed
            if (accept) begin
                if (index_q == LAST_INDEX) begin
                    bit_error_d = 1'b1;
                    index_d     = '0;
                end else begin
                    frame_d[index_q] = new_bit;
                    bit_valid_d      = 1'b1;
                    bit_value_d      = new_bit;
                    index_d          = index_q + 1'b1;
                end
            end
        end
    end

    // Decoder state and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= SYNC;
            on_cnt_q    <= '0;
            off_cnt_q   <= '0;
            index_q     <= '0;
            frame_q     <= '0;
            los_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_value_q <= 1'b0;
            bit_error_q <= 1'b0;
            minute_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            on_cnt_q    <= on_cnt_d;
            off_cnt_q   <= off_cnt_d;
            index_q     <= index_d;
            frame_q     <= frame_d;
            los_q       <= los_d;
            bit_valid_q <= bit_valid_d;
            bit_value_q <= bit_value_d;
            bit_error_q <= bit_error_d;
            minute_q    <= minute_d;
        end
    end

    assign bit_valid    = bit_valid_q;
    assign bit_value    = bit_value_q;
    assign bit_error    = bit_error_q;
    assign los          = los_q;
    assign bit_index    = index_q;
    assign minute_valid = minute_q;
    assign frame        = frame_q;

endmodule
